// File: rtl/demux_1_4_stream.sv
`default_nettype none
// ============================================================================
// Module   : demux_1_4_stream
// Brief    : 1:4 stream demultiplexer with per-channel one-entry holding
//            registers, independent valid/ready handshakes and delivery
//            counters.
// Revision : 1.0 - initial release
// ============================================================================

module demux_1_4_stream #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [CNT_W-1:0] out_count0,
    output logic [CNT_W-1:0] out_count1,
    output logic [CNT_W-1:0] out_count2,
    output logic [CNT_W-1:0] out_count3
);

    localparam int c_NUM_CH = 4;

    logic [c_NUM_CH-1:0] w_full;
    logic [c_NUM_CH-1:0] w_sel_onehot;
    logic [c_NUM_CH-1:0] w_acc_ch;
    logic [c_NUM_CH-1:0] w_deliver;
    logic                w_acc;
    logic [WIDTH-1:0]    w_q   [c_NUM_CH];
    logic [CNT_W-1:0]    w_cnt [c_NUM_CH];

    // Readiness looks only at the addressed channel, so a stalled channel
    // never blocks words destined elsewhere.
    assign in_ready  = !w_full[in_sel] || out_ready[in_sel];
    assign w_acc     = in_valid && in_ready;
    assign w_deliver = w_full & out_ready;

    always_comb begin
        w_sel_onehot         = '0;
        w_sel_onehot[in_sel] = 1'b1;
    end

    assign w_acc_ch = w_acc ? w_sel_onehot : '0;

    generate
        for (genvar gi = 0; gi < c_NUM_CH; gi++) begin : g_ch
            logic             r_full;
            logic [WIDTH-1:0] r_q;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_full <= 1'b0;
                    r_q    <= '0;
                    r_cnt  <= '0;
                end else begin
                    // A refill wins over a drain so the channel can stream
                    // one word per cycle; a drain alone leaves r_q stale.
                    if (w_acc_ch[gi]) begin
                        r_full <= 1'b1;
                        r_q    <= in_data;
                    end else if (w_deliver[gi]) begin
                        r_full <= 1'b0;
                    end
                    if (w_deliver[gi]) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_full[gi] = r_full;
            assign w_q[gi]    = r_q;
            assign w_cnt[gi]  = r_cnt;
        end
    endgenerate

    assign out_valid  = w_full;
    assign out_data0  = w_q[0];
    assign out_data1  = w_q[1];
    assign out_data2  = w_q[2];
    assign out_data3  = w_q[3];
    assign out_count0 = w_cnt[0];
    assign out_count1 = w_cnt[1];
    assign out_count2 = w_cnt[2];
    assign out_count3 = w_cnt[3];

endmodule

`default_nettype wire
